updown_counter_param: RTL and testbench



---
 rtl/counter_pkg.sv | 11 +
 rtl/counter_next_calc.sv | 59 +++++
 rtl/updown_counter_param.sv | 66 ++++++
 tb/tb_updown_counter_param.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-state calculation for one counting cycle.
// Arithmetic is one bit wider than the counter so nothing wraps modulo 2^WIDTH.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] counter,
    input  logic             d,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next,
    output logic             dir_next,
    output logic             tc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] up_clamped;
    logic [WIDTH-1:0] dn_clamped;
    logic [WIDTH-1:0] bound;
    logic             out_of_range;

    assign sum  = {1'b0, counter} + {1'b0, step};
    assign diff = {1'b0, counter} - {1'b0, step};

    // A set top bit in diff means the subtraction went below zero.
    assign up_clamped   = (sum > {1'b0, max_val}) ? max_val : sum[WIDTH-1:0];
    assign dn_clamped   = (diff[WIDTH] || (diff[WIDTH-1:0] < min_val)) ? min_val : diff[WIDTH-1:0];
    assign bound        = d ? max_val : min_val;
    assign out_of_range = (counter < min_val) || (counter > max_val);

    always_comb begin
        next     = counter;
        dir_next = d;
        tc_next  = 1'b0;
        if (step == '0) begin
            next = counter;
        end else if (out_of_range) begin
            next = d ? min_val : max_val;
        end else if (counter == bound) begin
            tc_next = 1'b1;
            case (mode)
                MODE_SAT: next = counter;
                MODE_BOUNCE: begin
                    // Reflect off the bound: step back the other way from it.
                    dir_next = ~d;
                    next     = d ? dn_clamped : up_clamped;
                end
                default: next = d ? min_val : max_val;
            endcase
        end else begin
            next = d ? up_clamped : dn_clamped;
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with bounds, step, load and wrap/saturate/bounce modes.
// Holds the registers and the rst > load > cfg_err > pause > count priority.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             dir_out,
    output logic             tc,
    output logic             cfg_err
);

    mode_t            mode_e;
    logic             d;
    logic [WIDTH-1:0] next;
    logic             dir_next;
    logic             tc_next;

    assign mode_e  = mode_t'(mode);
    assign cfg_err = (min_val > max_val);
    // Bounce keeps its own direction; other modes follow the direction input.
    assign d       = (mode_e == MODE_BOUNCE) ? dir_out : direction;

    counter_next_calc #(.WIDTH(WIDTH)) u_next_calc (
        .counter  (counter),
        .d        (d),
        .step     (step),
        .min_val  (min_val),
        .max_val  (max_val),
        .mode     (mode_e),
        .next     (next),
        .dir_next (dir_next),
        .tc_next  (tc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= RESET_VAL;
            dir_out <= 1'b1;
            tc      <= 1'b0;
        end else if (load) begin
            counter <= load_val;
            dir_out <= direction;
            tc      <= 1'b0;
        end else if (cfg_err || pause) begin
            tc <= 1'b0;
        end else begin
            counter <= next;
            dir_out <= dir_next;
            tc      <= tc_next;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param: directed scenarios then randomized traffic,
// expected values from an integer reference model, checked by a separate monitor.
module tb_updown_counter_param;

    localparam int W = 8;
    localparam logic [W-1:0] RV = 8'd0;

    logic         clk = 1'b0;
    logic         rst, pause, direction, load;
    logic [1:0]   mode;
    logic [W-1:0] min_val, max_val, step, load_val;
    logic [W-1:0] counter;
    logic         dir_out, tc, cfg_err;

    updown_counter_param #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .pause(pause), .direction(direction), .mode(mode),
        .min_val(min_val), .max_val(max_val), .step(step), .load(load),
        .load_val(load_val), .counter(counter), .dir_out(dir_out), .tc(tc),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit dir;
        bit tc;
        bit cfg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt  = 0;
    bit   m_dir  = 1'b1;

    // Reference model: one clock edge, expressed directly from the counting rules.
    task automatic model_step(input bit r, input bit ld, input bit ps, input bit dir_in,
                              input int md, input int lo, input int hi, input int st,
                              input int lv, output exp_t e);
        int  d;
        int  b;
        e.cfg = (lo > hi);
        e.tc  = 1'b0;
        if (r) begin
            m_cnt = int'(RV);
            m_dir = 1'b1;
        end else if (ld) begin
            m_cnt = lv;
            m_dir = dir_in;
        end else if (!(lo > hi) && !ps) begin
            d = (md == 2) ? int'(m_dir) : int'(dir_in);
            m_dir = d[0];
            if (st == 0) begin
                // hold
            end else if (m_cnt < lo || m_cnt > hi) begin
                m_cnt = (d == 1) ? lo : hi;
            end else begin
                b = (d == 1) ? hi : lo;
                if (m_cnt == b) begin
                    e.tc = 1'b1;
                    if (md == 1) begin
                        // saturate: stay put
                    end else if (md == 2) begin
                        m_dir = ~m_dir;
                        m_cnt = (d == 1) ? ((b - st < lo) ? lo : b - st)
                                         : ((b + st > hi) ? hi : b + st);
                    end else begin
                        m_cnt = (d == 1) ? lo : hi;
                    end
                end else begin
                    m_cnt = (d == 1) ? ((m_cnt + st > hi) ? hi : m_cnt + st)
                                     : ((m_cnt - st < lo) ? lo : m_cnt - st);
                end
            end
        end
        e.cnt = m_cnt;
        e.dir = m_dir;
    endtask

    task automatic cyc(input bit r, input bit ld, input bit ps, input bit dir_in,
                       input int md, input int lo, input int hi, input int st, input int lv);
        exp_t e;
        @(negedge clk);
        rst       = r;
        load      = ld;
        pause     = ps;
        direction = dir_in;
        mode      = 2'(md);
        min_val   = W'(lo);
        max_val   = W'(hi);
        step      = W'(st);
        load_val  = W'(lv);
        model_step(r, ld, ps, dir_in, md, lo, hi, st, lv, e);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp_v, $time);
        end
    endtask

    // Monitor: every edge after stimulus has been issued, compare the registered outputs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("counter", int'(counter), e.cnt);
            chk("dir_out", int'(dir_out), int'(e.dir));
            chk("tc", int'(tc), int'(e.tc));
            chk("cfg_err", int'(cfg_err), int'(e.cfg));
        end
    end

    initial begin
        int md, lo, hi, st, t;
        bit dr;
        rst = 1'b1; load = 1'b0; pause = 1'b0; direction = 1'b1; mode = 2'b00;
        min_val = '0; max_val = '1; step = 8'd1; load_val = '0;

        // 1: wrap up 2..5 from reset value 0
        cyc(1, 0, 0, 1, 0, 2, 5, 1, 0);
        repeat (6) cyc(0, 0, 0, 1, 0, 2, 5, 1, 0);
        // 2: wrap up 0..10 step 3 (clamps at 10 before wrapping)
        cyc(1, 0, 0, 1, 0, 0, 10, 3, 0);
        repeat (5) cyc(0, 0, 0, 1, 0, 0, 10, 3, 0);
        // 3: saturate down, then pause
        cyc(0, 1, 0, 0, 1, 4, 200, 5, 12);
        repeat (4) cyc(0, 0, 0, 0, 1, 4, 200, 5, 0);
        cyc(0, 0, 1, 0, 1, 4, 200, 5, 0);
        // 4: bounce 1..3
        cyc(0, 1, 0, 1, 2, 1, 3, 1, 1);
        repeat (6) cyc(0, 0, 0, 0, 2, 1, 3, 1, 0);
        // 5: full-range wrap without modular overflow, both directions
        cyc(0, 1, 0, 1, 0, 0, 255, 2, 254);
        repeat (2) cyc(0, 0, 0, 1, 0, 0, 255, 2, 0);
        cyc(0, 1, 0, 0, 0, 0, 255, 2, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 255, 2, 0);
        // 6: priorities and configuration error
        cyc(0, 1, 1, 1, 0, 0, 20, 1, 9);
        cyc(1, 1, 0, 1, 0, 0, 20, 1, 9);
        cyc(0, 0, 0, 1, 0, 0, 20, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 9, 3, 1, 0);
        // step of zero and degenerate min == max in each mode
        repeat (2) cyc(0, 0, 0, 1, 0, 0, 20, 0, 0);
        for (int m = 0; m < 4; m++) repeat (3) cyc(0, 0, 0, m[0], m, 7, 7, 2, 0);

        // Randomized traffic: configuration held for stretches so boundaries get hit.
        for (int blk = 0; blk < 200; blk++) begin
            md = int'($urandom_range(0, 3));
            lo = int'($urandom_range(0, 40));
            hi = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                              : lo + int'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0) hi = 255;
            st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 4));
            dr = 1'($urandom_range(0, 1));
            t  = int'($urandom_range(8, 20));
            for (int k = 0; k < t; k++) begin
                if ($urandom_range(0, 5) == 0) dr = ~dr;
                cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) == 0), dr, md, lo, hi, st,
                    int'($urandom_range(0, 255)));
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
